// File: rtl/ws2811_encoder_pkg.sv
// WS2811 transmit constants derived from the 40 MHz master clock, FSM encoding and a
// parameter-legality helper shared by the encoder files.
package ws2811_encoder_pkg;

   localparam int MASTER_HZ           = 40_000_000;
   localparam int MASTER_KHZ          = MASTER_HZ / 1000;
   localparam int WS2811_BIT_CYC      = MASTER_HZ / 800_000;          // 1.25 us
   localparam int WS2811_T1H_CYC      = MASTER_KHZ * 600 / 1_000_000; // 600 ns
   localparam int WS2811_T0H_CYC      = MASTER_KHZ * 250 / 1_000_000; // 250 ns
   localparam int WS2811_TX_RESET_CYC = MASTER_KHZ * 50 / 1000;       // 50 us

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HIGH,
      ST_LOW,
      ST_GAP
   } txState_t;

   function automatic bit timingLegal(input int bitCyc, input int t1h, input int t0h,
                                      input int rstCyc, input int cntW);
      return (t0h >= 1) && (t0h < t1h) && (t1h < bitCyc) &&
             (longint'(rstCyc) < (longint'(1) << cntW)) &&
             (longint'(bitCyc) < (longint'(1) << cntW));
   endfunction

endpackage

// File: rtl/ws2811_encoder_if.sv
// Byte handshake between a producer and the WS2811 encoder.
interface ws2811_encoder_if;
   logic [7:0] dataIn;
   logic       dataValid;
   logic       dataReady;

   modport master (output dataIn, output dataValid, input dataReady);
   modport slave  (input dataIn, input dataValid, output dataReady);
endinterface

// File: rtl/ws2811_tx_hold.sv
// Single-entry holding register in front of the WS2811 shifter; dataReady is the
// registered inverse of the next fill state.
module ws2811_tx_hold (
   input  logic                   masterClk,
   input  logic                   rst,
   ws2811_encoder_if.slave        dataIf,
   input  logic                   load,
   output logic [7:0]             holdByte,
   output logic                   holdFull
);

   logic take;
   logic fullNext;

   assign take     = dataIf.dataValid && dataIf.dataReady;
   // A load coinciding with a fresh handshake leaves the register full with the new byte.
   assign fullNext = take || (holdFull && !load);

   always_ff @(posedge masterClk or posedge rst) begin
      if (rst) begin
         holdFull         <= 1'b0;
         holdByte         <= '0;
         dataIf.dataReady <= 1'b1;
      end else begin
         holdFull         <= fullNext;
         dataIf.dataReady <= !fullNext;
         if (take) holdByte <= dataIf.dataIn;
      end
   end

endmodule

// File: rtl/ws2811_encoder.sv
// WS2811 800 kbps serialiser, MSB first, closing each session with a low reset gap.
// Optional bit counter output enabled by defining WS2811_ENC_BITCNT_EN.
module ws2811_encoder
   import ws2811_encoder_pkg::*;
#(
   parameter int BIT_CYC   = WS2811_BIT_CYC,
   parameter int T1H_CYC   = WS2811_T1H_CYC,
   parameter int T0H_CYC   = WS2811_T0H_CYC,
   parameter int RESET_CYC = WS2811_TX_RESET_CYC,
   parameter int CNT_W     = 16
) (
   input  logic                   masterClk,
   input  logic                   rst,
   ws2811_encoder_if.slave        dataIf,
   output logic                   dataOut,
`ifdef WS2811_ENC_BITCNT_EN
   output logic [15:0]            bitCnt,
`endif
   output logic                   active
);

   txState_t         state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] thrLast;
   logic [7:0]       shifter;
   logic [7:0]       holdByte;
   logic [2:0]       bitIdx;
   logic             holdFull;
   logic             load;
   logic             bitEnd;
   logic             lineQ;
   logic             actQ;

   ws2811_tx_hold uHold (
      .masterClk (masterClk),
      .rst       (rst),
      .dataIf    (dataIf),
      .load      (load),
      .holdByte  (holdByte),
      .holdFull  (holdFull)
   );

   assign bitEnd  = (state == ST_LOW) && (cnt == CNT_W'(BIT_CYC - 1));
   assign thrLast = shifter[bitIdx] ? CNT_W'(T1H_CYC - 1) : CNT_W'(T0H_CYC - 1);
   // A held byte starts from IDLE, or chains straight on after bit 0 with no gap.
   assign load    = holdFull && ((state == ST_IDLE) || (bitEnd && bitIdx == 3'd0));

   always_ff @(posedge masterClk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         shifter <= '0;
         bitIdx  <= '0;
         lineQ   <= 1'b0;
         actQ    <= 1'b0;
      end else if (load) begin
         shifter <= holdByte;
         bitIdx  <= 3'd7;
         cnt     <= '0;
         lineQ   <= 1'b1;
         actQ    <= 1'b1;
         state   <= ST_HIGH;
      end else begin
         case (state)
            ST_IDLE: begin
               lineQ <= 1'b0;
               actQ  <= 1'b0;
            end
            ST_HIGH: begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == thrLast) begin
                  lineQ <= 1'b0;
                  state <= ST_LOW;
               end
            end
            ST_LOW: begin
               if (bitEnd) begin
                  cnt <= '0;
                  if (bitIdx != 3'd0) begin
                     bitIdx <= bitIdx - 3'd1;
                     lineQ  <= 1'b1;
                     state  <= ST_HIGH;
                  end else begin
                     state  <= ST_GAP;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_GAP: begin
               lineQ <= 1'b0;
               if (cnt == CNT_W'(RESET_CYC - 1)) begin
                  cnt   <= '0;
                  actQ  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Output stage retimes line and active together so they move on the same edge.
   always_ff @(posedge masterClk or posedge rst) begin
      if (rst) begin
         dataOut <= 1'b0;
         active  <= 1'b0;
      end else begin
         dataOut <= lineQ;
         active  <= actQ;
      end
   end

`ifdef WS2811_ENC_BITCNT_EN
   always_ff @(posedge masterClk or posedge rst) begin
      if (rst)                                  bitCnt <= '0;
      else if (load && state == ST_IDLE)        bitCnt <= '0;
      else if (bitEnd && bitCnt != 16'hFFFF)    bitCnt <= bitCnt + 16'd1;
   end
`endif

`ifndef SYNTHESIS
   always @(posedge masterClk)
      assert (timingLegal(BIT_CYC, T1H_CYC, T0H_CYC, RESET_CYC, CNT_W))
      else $error("ws2811_encoder: illegal timing parameters");
`endif

endmodule

// File: tb/tb_ws2811_encoder.sv
// Scoreboard bench for ws2811_encoder: the driver queues expected bits per accepted byte,
// a line monitor measures pulse widths, bit periods and gap length against WS2811 timing.
module tb_ws2811_encoder;

   localparam int BIT   = 50;
   localparam int T1H   = 24;
   localparam int T0H   = 10;
   localparam int GAPC  = 2000;

   logic masterClk = 1'b0;
   logic rst       = 1'b1;
   logic dataOut;
   logic active;
`ifdef WS2811_ENC_BITCNT_EN
   logic [15:0] bitCnt;
`endif

   ws2811_encoder_if dIf ();

   ws2811_encoder dut (
      .masterClk (masterClk),
      .rst       (rst),
      .dataIf    (dIf),
      .dataOut   (dataOut),
`ifdef WS2811_ENC_BITCNT_EN
      .bitCnt    (bitCnt),
`endif
      .active    (active)
   );

   initial forever #5 masterClk = ~masterClk;

   int cyc = 0;
   always @(posedge masterClk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   bit bitQ[$];
   int rises[$];
   int lastRise = 0, firstRise = 0, lastActFall = 0, idleLen = 0, readyRise = 0;

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Line monitor: decodes the waveform and pops the expected bit on every falling edge.
   initial begin
      logic prevLine, prevAct, prevReady;
      bit   inSess, e;
      prevLine = 1'b0; prevAct = 1'b0; prevReady = 1'b1; inSess = 1'b0;
      forever begin
         @(negedge masterClk);
         if (rst) begin
            prevLine = 1'b0; prevAct = 1'b0; prevReady = 1'b1; inSess = 1'b0;
         end else begin
            if (dataOut && !prevLine) begin
               chk("riseInSession", int'(active), 1);
               if (inSess) chk("bitPeriod", cyc - lastRise, BIT);
               else firstRise = cyc;
               inSess   = 1'b1;
               lastRise = cyc;
               rises.push_back(cyc);
            end
            if (!dataOut && prevLine) begin
               chk("bitQueued", int'(bitQ.size() > 0), 1);
               if (bitQ.size() > 0) begin
                  e = bitQ.pop_front();
                  chk("highTime", cyc - lastRise, e ? T1H : T0H);
               end
            end
            if (active && !prevAct) begin
               chk("activeWithLine", int'(dataOut), 1);
               idleLen = cyc - lastActFall;
            end
            if (!active && prevAct) begin
               chk("gapLength", cyc - lastRise, BIT + GAPC);
               inSess      = 1'b0;
               lastActFall = cyc;
            end
            if (dIf.dataReady && !prevReady) readyRise = cyc;
            prevLine  = dataOut;
            prevAct   = active;
            prevReady = dIf.dataReady;
         end
      end
   end

   task automatic tick();
      @(posedge masterClk);
      #1;
   endtask

   task automatic sendByte(input logic [7:0] b, output int hs);
      int n;
      n = 0;
      hs = 0;
      dIf.dataIn    = b;
      dIf.dataValid = 1'b1;
      while (!dIf.dataReady && n < 6000) begin
         tick();
         n++;
      end
      chk("readyWait", int'(n < 6000), 1);
      if (n < 6000) begin
         tick();
         hs = cyc;
         for (int i = 7; i >= 0; i--) bitQ.push_back(b[i]);
         chk("readyDrop", int'(dIf.dataReady), 0);
      end
      dIf.dataValid = 1'b0;
      dIf.dataIn    = 8'($urandom);
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!(!active && dIf.dataReady && bitQ.size() == 0) && n < 8000);
      chk("idleWait", int'(n < 8000), 1);
   endtask

   initial begin
      int hs, t, nb;
      dIf.dataIn    = 8'h00;
      dIf.dataValid = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      chk("rstDataOut", int'(dataOut), 0);
      chk("rstActive", int'(active), 0);
      chk("rstReady", int'(dIf.dataReady), 1);
      rst = 1'b0;
      repeat (2) tick();

      // Single byte: latency and full session
      rises.delete();
      sendByte(8'hA5, hs);
      waitIdle();
      chk("latency", firstRise - hs, 2);
      chk("bitsA5", rises.size(), 8);

      // Back-to-back bytes, second queued while the first shifts
      rises.delete();
      sendByte(8'hFF, hs);
      sendByte(8'h00, hs);
      waitIdle();
      chk("bitsB2B", rises.size(), 16);
      if (rises.size() == 16) chk("readyAtLoad", readyRise, rises[8] - 1);

      // Byte arriving 100 cycles into the gap
      rises.delete();
      sendByte(8'h80, hs);
      t = 0;
      while ((bitQ.size() != 0 || cyc < lastRise + BIT + 99) && t < 3000) begin
         tick();
         t++;
      end
      sendByte(8'h01, hs);
      waitIdle();
      chk("gapIdleLen", idleLen, 1);
      chk("bitsGapPend", rises.size(), 16);

      // Async reset during the high phase of bit 3
      rises.delete();
      sendByte(8'hFF, hs);
      t = 0;
      while (rises.size() < 5 && t < 1000) begin
         tick();
         t++;
      end
      repeat (4) tick();
      #3 rst = 1'b1;
      #1;
      chk("midRstDataOut", int'(dataOut), 0);
      chk("midRstActive", int'(active), 0);
      chk("midRstReady", int'(dIf.dataReady), 1);
      bitQ.delete();
      tick();
      tick();
      rst = 1'b0;
      tick();
      rises.delete();
      sendByte(8'h5A, hs);
      waitIdle();
      chk("postRstLatency", firstRise - hs, 2);
      chk("bitsPostRst", rises.size(), 8);

      // Loopback pair
      rises.delete();
      sendByte(8'h3C, hs);
      sendByte(8'hC3, hs);
      waitIdle();
      chk("bitsLoop", rises.size(), 16);

`ifdef WS2811_ENC_BITCNT_EN
      sendByte(8'h12, hs);
      sendByte(8'h34, hs);
      sendByte(8'h56, hs);
      waitIdle();
      chk("bitCnt24", int'(bitCnt), 24);
      rises.delete();
      sendByte(8'h55, hs);
      t = 0;
      while (rises.size() == 0 && t < 100) begin
         tick();
         t++;
      end
      chk("bitCntClear", int'(bitCnt), 0);
      waitIdle();
`endif

      // Randomized bursts with random spacing (some land inside the gap)
      for (int it = 0; it < 10; it++) begin
         nb = $urandom_range(1, 3);
         for (int k = 0; k < nb; k++) sendByte(8'($urandom), hs);
         repeat ($urandom_range(0, 600)) tick();
      end
      waitIdle();
      chk("bitQEmpty", bitQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
